// File: rtl/uart_rx_controller.sv
// UART receiver: 2-flop rx synchronizer, oversampled frame FSM and one-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module uart_rx_controller #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] data_out,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            rx_busy,
  output logic            frame_err,
  output logic            overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TICK_W   = $clog2(TICK_MAX);
  localparam int BIT_W    = $clog2(DBIT + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t            state_r;
  logic              rx_meta_r;
  logic              rx_sync_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DBIT-1:0]   shift_r;
`ifdef UART_RX_PARITY_EN
  logic              parity_bit_r;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic parity_mismatch(input logic [DBIT-1:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  // Two-flop synchronizer, preset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame sequencer, holding register and registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      tick_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      rx_busy      <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_r <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      // A load in STOP below overrides this consume.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end else begin
        data_valid <= data_valid;
      end

      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r    <= START;
            tick_cnt_r <= '0;
            rx_busy    <= 1'b1;
          end else begin
            rx_busy    <= 1'b0;
          end
        end

        START: begin
          if (s_tick) begin
            if (tick_cnt_r == HALF_LAST) begin
              tick_cnt_r <= '0;
              if (!rx_sync_r) begin
                state_r   <= DATA;
                bit_cnt_r <= '0;
              end else begin
                state_r   <= IDLE;
                rx_busy   <= 1'b0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (tick_cnt_r == BIT_LAST) begin
              tick_cnt_r <= '0;
              shift_r    <= {rx_sync_r, shift_r[DBIT-1:1]};
              bit_cnt_r  <= bit_cnt_r + 1'b1;
              if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick_cnt_r == BIT_LAST) begin
              tick_cnt_r   <= '0;
              parity_bit_r <= rx_sync_r;
              state_r      <= STOP;
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            if (tick_cnt_r == STOP_LAST) begin
              tick_cnt_r  <= '0;
              state_r     <= IDLE;
              rx_busy     <= 1'b0;
              data_out    <= shift_r;
              data_valid  <= 1'b1;
              frame_err   <= ~rx_sync_r;
              overrun_err <= data_valid & ~data_ready;
`ifdef UART_RX_PARITY_EN
              parity_err  <= parity_mismatch(shift_r, parity_bit_r);
`endif
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end

        default: begin
          state_r    <= IDLE;
          tick_cnt_r <= '0;
          rx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: 8 data bits, 16 ticks/bit, one s_tick every 4 clocks.
module tb_uart_rx_controller;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks;
  int errors;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       oerr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_controller #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick: one clock wide every fourth clock, changed on the falling edge.
  initial begin
    logic [1:0] div;
    s_tick = 1'b0;
    div    = 2'd0;
    forever begin
      @(negedge clk);
      s_tick = (div == 2'd3);
      div    = div + 2'd1;
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (s_tick !== 1'b1) @(posedge clk);
  endtask

  // Drives one frame aligned to tick edges; returns just after the stop level is applied.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic exp_oerr);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_b;
    e.oerr = exp_oerr;
    e.perr = ^{d, par_b};
    exp_q.push_back(e);
    wait_tick();
    #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) wait_tick();
      #1 rx = d[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (16) wait_tick();
    #1 rx = par_b;
`endif
    repeat (16) wait_tick();
    #1 rx = stop_b;
  endtask

  task automatic check_load(input string name);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (rx_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s timeout: rx_busy=%b after %0d clks, required 0", name, rx_busy, n);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty on load", name);
    end else begin
      e = exp_q.pop_front();
      checks += 4;
      if (data_out !== e.data) begin
        errors++; $display("FAIL %s data_out: got %h, expected %h", name, data_out, e.data);
      end
      if (data_valid !== 1'b1) begin
        errors++; $display("FAIL %s data_valid: got %b, expected 1", name, data_valid);
      end
      if (frame_err !== e.ferr) begin
        errors++; $display("FAIL %s frame_err: got %b, expected %b", name, frame_err, e.ferr);
      end
      if (overrun_err !== e.oerr) begin
        errors++; $display("FAIL %s overrun_err: got %b, expected %b", name, overrun_err, e.oerr);
      end
`ifdef UART_RX_PARITY_EN
      checks++;
      if (parity_err !== e.perr) begin
        errors++; $display("FAIL %s parity_err: got %b, expected %b", name, parity_err, e.perr);
      end
`endif
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse width: frame_err=%b overrun_err=%b one clk later, expected 0 0",
               name, frame_err, overrun_err);
    end
  endtask

  task automatic consume(input string name);
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL %s consume: data_valid=%b, expected 0", name, data_valid);
    end
  endtask

  task automatic check_idle(input string name);
    repeat (20) wait_tick();
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL %s idle: rx_busy=%b, expected 0", name, rx_busy);
    end
  endtask

  task automatic test_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || rx_busy !== 1'b0 ||
        frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: out=%h v=%b busy=%b fe=%b oe=%b, expected all 0",
               data_out, data_valid, rx_busy, frame_err, overrun_err);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset release: busy=%b v=%b, expected 0 0", rx_busy, data_valid);
    end
  endtask

  task automatic test_glitch();
    wait_tick();
    #1 rx = 1'b0;
    repeat (5) wait_tick();
    #1 rx = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL glitch start: rx_busy=%b, expected 1", rx_busy);
    end
    check_idle("glitch");
    checks++;
    if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL glitch output: v=%b fe=%b, expected 0 0", data_valid, frame_err);
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    check_load("frame_a5");
    consume("frame_a5");
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    check_load("frame_3c_ferr");
    rx = 1'b1;
    check_idle("frame_3c_ferr");
    consume("frame_3c_ferr");
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    check_load("ovr_11");
    send_frame(8'h22, 1'b1, ^8'h22, 1'b1);
    check_load("ovr_22");
    // data_ready raised for exactly the load clock, 8 ticks after the stop level starts.
    send_frame(8'h33, 1'b1, ^8'h33, 1'b0);
    repeat (7) wait_tick();
    repeat (3) @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
    check_load("ready_on_load_33");
    consume("ready_on_load_33");
  endtask

  task automatic test_break();
    exp_t e;
    send_frame(8'h55, 1'b0, ^8'h55, 1'b0);
    check_load("break_first");
    e.data = 8'h00;
    e.ferr = 1'b1;
    e.oerr = 1'b1;
    e.perr = 1'b0;
    exp_q.push_back(e);
    check_load("break_repeat");
    rx = 1'b1;
    check_idle("break");
    consume("break");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check_load("parity_bad_07");
    consume("parity_bad_07");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_load("parity_ok_07");
    consume("parity_ok_07");
  endtask
`endif

  task automatic test_reset_mid_frame();
    send_frame(8'h6E, 1'b1, ^8'h6E, 1'b0);
    check_load("pre_reset_6e");
    wait_tick();
    #1 rx = 1'b0;
    repeat (40) wait_tick();
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || rx_busy !== 1'b0 ||
        frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-frame: out=%h v=%b busy=%b fe=%b oe=%b, expected all 0",
               data_out, data_valid, rx_busy, frame_err, overrun_err);
    end
    rx = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset_mid_frame");
    checks++;
    if (data_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset mid-frame after: v=%b pending=%0d, expected 0 0", data_valid, exp_q.size());
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b0;
    test_reset();
    test_glitch();
    test_basic();
    test_frame_err();
    test_overrun();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
